red_secuencial_der_izq: RTL

//  Bit-serial sequential counterpart of the iterative comparator network: scans words A and B

---
 rtl/red_secuencial_der_izq_pkg.sv | 17 +
 rtl/red_secuencial_der_izq_if.sv | 24 ++
 rtl/celda_serial_der_izq.sv | 17 +
 rtl/red_secuencial_der_izq.sv | 95 +++++++++
 4 files changed

// File: rtl/red_secuencial_der_izq_pkg.sv
// Shared encodings for the serial right-to-left comparator: FSM states and P/Q comparison state.
package red_secuencial_der_izq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // P/Q pair: {P,Q}; 11 can never be produced by the cell
  typedef logic [1:0] pq_t;

  localparam pq_t PQ_EQ  = 2'b00;
  localparam pq_t PQ_AGT = 2'b10;
  localparam pq_t PQ_BGT = 2'b01;

endpackage

// File: rtl/red_secuencial_der_izq_if.sv
// Request/result bundle of the serial comparator: operands with start, busy/done and the result flags.
interface red_secuencial_der_izq_if #(
  parameter int unsigned N = 3
);

  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         busy;
  logic         done;
  logic         Zout;
  logic         Zeq;

  modport master (
    output start, A, B,
    input  busy, done, Zout, Zeq
  );

  modport slave (
    input  start, A, B,
    output busy, done, Zout, Zeq
  );

endinterface

// File: rtl/celda_serial_der_izq.sv
// One comparison cell: a differing bit pair overrides the running P/Q, an equal pair passes it through.
module celda_serial_der_izq (
  input  logic p,
  input  logic q,
  input  logic Ai,
  input  logic Bi,
  output logic P,
  output logic Q
);

  logic differ;

  assign differ = Ai ^ Bi;
  assign P      = differ ? Ai  : p;
  assign Q      = differ ? ~Ai : q;

endmodule

// File: rtl/red_secuencial_der_izq.sv
// Bit-serial A>B / A==B comparator: scans LSB first through a single reused cell, one bit per clock.
module red_secuencial_der_izq
  import red_secuencial_der_izq_pkg::*;
#(
  parameter int unsigned N = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  red_secuencial_der_izq_if.slave bus
);

  localparam int unsigned CW   = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [N-1:0]  sa;
  logic [N-1:0]  sb;
  pq_t           pq;
  logic [CW-1:0] count;
  logic          busy_r;
  logic          done_r;
  logic          zout_r;
  logic          zeq_r;
  logic          p_nx;
  logic          q_nx;
  pq_t           pq_nx;
  logic          accept;

  celda_serial_der_izq u_celda (
    .p  (pq[1]),
    .q  (pq[0]),
    .Ai (sa[0]),
    .Bi (sb[0]),
    .P  (p_nx),
    .Q  (q_nx)
  );

  assign pq_nx  = {p_nx, q_nx};
  // FIN accepts a new request exactly like IDLE, giving back-to-back scans
  assign accept = bus.start && ((state == ST_IDLE) || (state == ST_FIN));

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      sa     <= '0;
      sb     <= '0;
      pq     <= PQ_EQ;
      count  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      zout_r <= 1'b0;
      zeq_r  <= 1'b0;
    end else if (accept) begin
      state  <= ST_SCAN;
      sa     <= bus.A;
      sb     <= bus.B;
      pq     <= PQ_EQ;
      count  <= '0;
      busy_r <= 1'b1;
      done_r <= 1'b0;
      zout_r <= 1'b0;
      zeq_r  <= 1'b0;
    end else begin
      case (state)
        ST_SCAN: begin
          pq <= pq_nx;
          sa <= sa >> 1;
          sb <= sb >> 1;
          if (count == LAST) begin
            state  <= ST_FIN;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            zout_r <= (pq_nx == PQ_AGT);
            zeq_r  <= (pq_nx == PQ_EQ);
          end else begin
            count <= count + CW'(1);
          end
        end
        ST_FIN: begin
          state  <= ST_IDLE;
          done_r <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.Zout = zout_r;
  assign bus.Zeq  = zeq_r;

endmodule
